// File: rtl/life_sequencer.sv
// Generation scheduler for the Conway-life engine.
// Sequences clear / compute / swap / render jobs through the agent selector.
module life_sequencer #(
    parameter int GEN_W = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             clear_req,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             sel_ready,
    output logic             sel_start,
    output logic [1:0]       sel_agent,
    output logic             busy,
    output logic [GEN_W-1:0] generation,
    output logic             gen_done
);

    typedef enum logic [3:0] {
        CLR_ISSUE,
        CLR_WAIT,
        IDLE,
        CMP_ISSUE,
        CMP_WAIT,
        SWP_ISSUE,
        SWP_WAIT,
        RND_ISSUE,
        RND_WAIT,
        DELAY
    } state_t;

    state_t           state;
    state_t           state_n;
    state_t           exit_n;
    logic             guard;
    logic [DIV_W-1:0] delay_cnt;
    logic             clear_pending;
    logic             accept;
    logic             done;
    logic             clr_any;
    logic             rnd_done;
    logic             clr_done;

    function automatic logic is_issue(input state_t s);
        return (s == CLR_ISSUE) || (s == CMP_ISSUE) ||
               (s == SWP_ISSUE) || (s == RND_ISSUE);
    endfunction

    function automatic logic [1:0] agent_of(input state_t s);
        logic [1:0] a;
        unique case (s)
            CMP_ISSUE, CMP_WAIT: a = 2'd1;
            SWP_ISSUE, SWP_WAIT: a = 2'd2;
            RND_ISSUE, RND_WAIT: a = 2'd3;
            default:             a = 2'd0;
        endcase
        return a;
    endfunction

    // sel_start is registered, so acceptance needs both sides asserted;
    // the first WAIT cycle (guard) ignores the stale ready.
    assign accept   = sel_start && sel_ready;
    assign done     = !guard && sel_ready;
    assign clr_any  = clear_pending || clear_req;
    assign rnd_done = (state == RND_WAIT) && done;
    assign clr_done = (state == CLR_WAIT) && done;

    // Decision taken when leaving the inter-generation gap.
    always_comb begin
        exit_n = IDLE;
        if (clr_any) begin
            exit_n = CLR_ISSUE;
        end else if (run) begin
            exit_n = CMP_ISSUE;
        end
    end

    // Next-state selection for the job sequence.
    always_comb begin
        state_n = state;
        unique case (state)
            CLR_ISSUE: if (accept) state_n = CLR_WAIT;
            CLR_WAIT:  if (done) state_n = IDLE;
            IDLE: begin
                if (clr_any) begin
                    state_n = CLR_ISSUE;
                end else if (run || step) begin
                    state_n = CMP_ISSUE;
                end
            end
            CMP_ISSUE: if (accept) state_n = CMP_WAIT;
            CMP_WAIT:  if (done) state_n = SWP_ISSUE;
            SWP_ISSUE: if (accept) state_n = SWP_WAIT;
            SWP_WAIT:  if (done) state_n = RND_ISSUE;
            RND_ISSUE: if (accept) state_n = RND_WAIT;
            RND_WAIT: begin
                if (done) begin
                    state_n = (rate_div != '0) ? DELAY : exit_n;
                end
            end
            DELAY: if (delay_cnt <= DIV_W'(1)) state_n = exit_n;
            default: state_n = CLR_ISSUE;
        endcase
    end

    // State, registered outputs, counters and sticky clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CLR_ISSUE;
            sel_start     <= 1'b0;
            sel_agent     <= 2'd0;
            busy          <= 1'b1;
            generation    <= '0;
            gen_done      <= 1'b0;
            delay_cnt     <= '0;
            clear_pending <= 1'b0;
            guard         <= 1'b0;
        end else begin
            state     <= state_n;
            sel_start <= is_issue(state_n);
            busy      <= (state_n != IDLE);
            guard     <= accept;
            gen_done  <= rnd_done;
            if (state_n != IDLE && state_n != DELAY) begin
                sel_agent <= agent_of(state_n);
            end
            if (rnd_done) begin
                generation <= generation + GEN_W'(1);
            end else if (clr_done) begin
                generation <= '0;
            end
            if (rnd_done) begin
                delay_cnt <= rate_div;
            end else if (state == DELAY && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - DIV_W'(1);
            end
            if (state_n == CLR_ISSUE && state != CLR_ISSUE) begin
                clear_pending <= 1'b0;
            end else if (clear_req && state != IDLE) begin
                clear_pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/life_sequencer.md
# life_sequencer

Generation scheduler for the Conway-life engine. It sits upstream of the four-agent selector and drives its select/start/ready handshake. It runs a power-on clear, then one compute → swap → render sequence per generation, under run/step/clear control with a programmable inter-generation delay. It maintains the generation counter shown to the host.

## Interface

Parameters:
- GEN_W, 16: width of the generation counter.
- DIV_W, 24: width of the inter-generation delay.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; free-running generations while high.
- step  in  1  single-cycle pulse; one generation when idle and run low.
- clear_req  in  1  single-cycle pulse; request board clear.
- rate_div  in  DIV_W  idle cycles inserted between generations; sampled at render completion.
- sel_ready  in  1  selector ready (AND of all agent readies).
- sel_start  out  1  start request to selector.
- sel_agent  out  2  agent select to selector: 0 clear, 1 compute, 2 swap buffers, 3 render.
- busy  out  1  high in every state except IDLE.
- generation  out  GEN_W  completed-generation count.
- gen_done  out  1  one-cycle pulse when a generation's render completes.

## Operation

- Agent contract: an agent accepts start on a cycle with sel_start=1 and sel_ready=1. It deasserts ready on the following cycle and reasserts ready when done.
- Each job uses two states, ISSUE and WAIT:
  - ISSUE: sel_start=1 and sel_agent=job. The FSM holds ISSUE until sel_ready=1, which is the acceptance cycle, then moves to WAIT.
  - WAIT: sel_start=0 and sel_agent=job. sel_ready is ignored on the first WAIT cycle (guard). The FSM leaves WAIT on the first subsequent cycle with sel_ready=1.
- States: CLR_ISSUE, CLR_WAIT, IDLE, CMP_ISSUE, CMP_WAIT, SWP_ISSUE, SWP_WAIT, RND_ISSUE, RND_WAIT, DELAY.
- Transitions:
  - After reset → CLR_ISSUE (power-on clear).
  - CLR_WAIT done → IDLE; generation cleared to 0.
  - IDLE: clear_req → CLR_ISSUE. Else run=1 or step=1 → CMP_ISSUE. Else stay.
  - CMP_WAIT done → SWP_ISSUE.
  - SWP_WAIT done → RND_ISSUE.
  - RND_WAIT done: generation += 1 (wraps at 2^GEN_W−1 → 0) and gen_done pulses. Delay counter loads rate_div. Next state is DELAY if rate_div≠0, else the DELAY-exit rule is applied immediately in the same cycle.
  - DELAY: counter decrements each cycle. When it reaches 0, exit as IDLE would: clear pending → CLR_ISSUE; else run=1 → CMP_ISSUE; else IDLE.
- clear_req arriving in any non-IDLE state sets a sticky clear_pending flag. The flag is consumed at the next IDLE or DELAY exit. The current generation always completes first.
- step pulses received while busy are dropped. step has no effect while run=1, since run already schedules generations.
- Priority at each decision point: clear_pending/clear_req > run > step.
- sel_agent holds its last value in IDLE and DELAY; reset value is 0.

## Timing

- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Reset values:
  - sel_start=0, sel_agent=0, busy=1 (heading to CLR), generation=0, gen_done=0.
  - delay counter=0, clear_pending=0.
- sel_start asserts one cycle after reset deassertion (in CLR_ISSUE).
- Minimum job latency, ISSUE entry to WAIT exit with ready immediately available: acceptance cycle + guard cycle + done cycle = 3 cycles.
- Minimum generation period with rate_div=0 and single-cycle agents: 9 cycles.
- rate_div=N adds exactly N DELAY cycles between gen_done and the next CMP_ISSUE.
- Reset asserted mid-job: immediate return to reset values. The aborted agent is not waited for; the power-on clear reissues once the selector reports ready.
- gen_done and the generation increment occur on the same clock edge.

## Test plan

- Reset release, agents ready after 5 cycles: sel_start=1 with sel_agent=0 is held until ready; the FSM then reaches IDLE with generation=0 and busy=0.
- step pulse in IDLE, single-cycle agents: sel_agent goes 1, 2, 3 in order; gen_done pulses once; generation=1; the FSM returns to IDLE after 9 cycles.
- run=1 with rate_div=4 for 3 generations: gen_done pulses are exactly 13 cycles apart and generation=3.
- clear_req during CMP_WAIT: compute, swap and render still complete (generation increments), then clear is issued and generation returns to 0.
- Generation counter at 2^GEN_W−1, step: generation wraps to 0 and gen_done=1.
- Reset asserted during RND_WAIT: all outputs take reset values on that edge, and the next start issued is a clear (sel_agent=0).
